ps2_mouse_iface: RTL and testbench



---
 rtl/ps2_mouse_iface.sv | 224 ++++++++++++++++++++++
 tb/tb_ps2_mouse_iface.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_iface.sv
// ps2_mouse_iface: host-side PS/2 mouse controller (power-on handshake AA/ID/F4/FA, stream packet decode).
// Optional build macro PS2_PARITY_CHECK_EN: discard received bytes whose odd parity is wrong.
module ps2_mouse_iface #(
    parameter int WATCHDOG_TIMER_VALUE_PP = 10800,
    parameter int WATCHDOG_TIMER_BITS_PP  = 14,
    parameter int DEBOUNCE_TIMER_VALUE_PP = 100,
    parameter int DEBOUNCE_TIMER_BITS_PP  = 7
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire        ps2_clk,
    inout  wire        ps2_data,
    output logic       left_button,
    output logic       right_button,
    output logic [8:0] x_increment,
    output logic [8:0] y_increment,
    output logic       data_ready,
    input  logic       read,
    output logic       error_no_ack
);

    typedef enum logic [2:0] {WAIT_BAT, WAIT_ID, INHIBIT, TX, ACK, WAIT_FA, STREAM} state_t;

    localparam logic [7:0] ENABLE_CMD = 8'hF4;
    // Host-to-device frame indexed by falls seen so far; entries past the parity bit keep data released.
    localparam logic [15:0] TX_FRAME = {6'h3F, ~^ENABLE_CMD, ENABLE_CMD, 1'b0};
    localparam logic [WATCHDOG_TIMER_BITS_PP-1:0] WD_LAST =
        WATCHDOG_TIMER_BITS_PP'(WATCHDOG_TIMER_VALUE_PP - 1);
    localparam logic [DEBOUNCE_TIMER_BITS_PP-1:0] DEB_LAST =
        DEBOUNCE_TIMER_BITS_PP'(DEBOUNCE_TIMER_VALUE_PP - 1);

    state_t state, state_next;

    logic [1:0]                        clk_sync;
    logic [1:0]                        data_sync;
    logic                              clk_stable;
    logic                              fall;
    logic [DEBOUNCE_TIMER_BITS_PP-1:0] deb_count;
    logic [WATCHDOG_TIMER_BITS_PP-1:0] timer;
    logic [3:0]                        bit_count;
    logic [9:0]                        rx_shift;
    logic [10:0]                       rx_frame;
    logic [7:0]                        rx_byte;
    logic                              parity_ok;
    logic                              rx_state;
    logic                              rx_done;
    logic                              rx_valid;
    logic                              rx_bad;
    logic [1:0]                        byte_index;
    logic [3:0]                        byte0_bits;
    logic [7:0]                        byte1;
    logic                              frame_active;
    logic                              wd_expire;
    logic                              latch_packet;
    logic                              drive_clk_low;
    logic                              drive_data_low;

    assign ps2_clk  = drive_clk_low  ? 1'b0 : 1'bz;
    assign ps2_data = drive_data_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // A new clock level must persist for the full debounce window before it is believed.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_stable <= 1'b1;
            deb_count  <= '0;
            fall       <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_sync[1] == clk_stable) begin
                deb_count <= '0;
            end else if (deb_count == DEB_LAST) begin
                deb_count  <= '0;
                clk_stable <= clk_sync[1];
                fall       <= ~clk_sync[1];
            end else begin
                deb_count <= deb_count + 1'b1;
            end
        end
    end

    assign rx_state = (state == WAIT_BAT) || (state == WAIT_ID) ||
                      (state == WAIT_FA)  || (state == STREAM);
    assign rx_frame = {data_sync[1], rx_shift};
    assign rx_byte  = rx_frame[8:1];
`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok = ^rx_frame[9:1];
`else
    assign parity_ok = rx_frame[9] | 1'b1;
`endif
    assign rx_done  = fall && rx_state && (bit_count == 4'd10);
    assign rx_valid = rx_done && !rx_frame[0] && rx_frame[10] && parity_ok;
    assign rx_bad   = rx_done && !rx_valid;

    // The watchdog also covers gaps between packet bytes so a stalled packet cannot poison the next.
    assign frame_active = (bit_count != 4'd0) || (byte_index != 2'd0);
    assign wd_expire    = frame_active && (state != INHIBIT) && (timer == WD_LAST);
    assign latch_packet = rx_valid && (state == STREAM) && (byte_index == 2'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
        end else if ((state_next != state) || wd_expire || (fall && state != INHIBIT)) begin
            timer <= '0;
        end else if ((state == INHIBIT) || frame_active) begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_count <= '0;
            rx_shift  <= '0;
        end else begin
            if (fall) begin
                rx_shift <= {data_sync[1], rx_shift[9:1]};
            end
            if ((state == INHIBIT) || wd_expire || (fall && (rx_done || state == ACK))) begin
                bit_count <= '0;
            end else if (fall) begin
                bit_count <= bit_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_index <= '0;
            byte0_bits <= '0;
            byte1      <= '0;
        end else if (wd_expire || rx_bad) begin
            byte_index <= '0;
        end else if (rx_valid && (state == STREAM)) begin
            case (byte_index)
                2'd0: begin
                    if (rx_byte[3]) begin
                        byte0_bits <= {rx_byte[5], rx_byte[4], rx_byte[1], rx_byte[0]};
                        byte_index <= 2'd1;
                    end
                end
                2'd1: begin
                    byte1      <= rx_byte;
                    byte_index <= 2'd2;
                end
                default: byte_index <= 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            left_button  <= 1'b0;
            right_button <= 1'b0;
            x_increment  <= '0;
            y_increment  <= '0;
            data_ready   <= 1'b0;
            error_no_ack <= 1'b0;
        end else begin
            if (latch_packet) begin
                left_button  <= byte0_bits[0];
                right_button <= byte0_bits[1];
                x_increment  <= {byte0_bits[2], byte1};
                y_increment  <= {byte0_bits[3], rx_byte};
                data_ready   <= 1'b1;
            end else if (data_ready && read) begin
                data_ready <= 1'b0;
            end
            if ((state == ACK) && fall && data_sync[1]) begin
                error_no_ack <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WAIT_BAT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_BAT: if (rx_valid && rx_byte == 8'hAA) state_next = WAIT_ID;
            WAIT_ID:  if (rx_valid) state_next = INHIBIT;
            INHIBIT:  if (timer == WD_LAST) state_next = TX;
            TX: begin
                if (wd_expire)                          state_next = INHIBIT;
                else if (fall && bit_count == 4'd9)     state_next = ACK;
            end
            ACK: begin
                if (wd_expire)  state_next = INHIBIT;
                else if (fall)  state_next = data_sync[1] ? INHIBIT : WAIT_FA;
            end
            WAIT_FA:  if (rx_valid) state_next = (rx_byte == 8'hFA) ? STREAM : INHIBIT;
            STREAM:   state_next = STREAM;
            default:  state_next = WAIT_BAT;
        endcase
    end

    always_comb begin
        drive_clk_low  = 1'b0;
        drive_data_low = 1'b0;
        case (state)
            INHIBIT: begin
                drive_clk_low  = 1'b1;
                drive_data_low = 1'b1;
            end
            TX:      drive_data_low = ~TX_FRAME[bit_count];
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ps2_mouse_iface.sv
// tb_ps2_mouse_iface: emulates a PS/2 mouse (device side) against ps2_mouse_iface with directed vectors.
// Shortened watchdog/debounce values keep the run short while preserving the protocol ratios.
module tb_ps2_mouse_iface;

    localparam int WD   = 2000;
    localparam int DEB  = 20;
    localparam int HALF = 50;

    logic       clk = 1'b0;
    logic       reset;
    logic       read;
    logic       dev_clk_low  = 1'b0;
    logic       dev_data_low = 1'b0;
    wire        ps2_clk;
    wire        ps2_data;
    logic       left_button;
    logic       right_button;
    logic [8:0] x_increment;
    logic [8:0] y_increment;
    logic       data_ready;
    logic       error_no_ack;

    int checks = 0;
    int errors = 0;
    int ready_pulses = 0;
    int ready_cycles = 0;
    int low_run = 0;
    int last_inhibit = 0;
    int inhibit_seen = 0;
    logic ready_prev = 1'b0;

    pullup (ps2_clk);
    pullup (ps2_data);
    assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
    assign ps2_data = dev_data_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    ps2_mouse_iface #(
        .WATCHDOG_TIMER_VALUE_PP(WD),
        .WATCHDOG_TIMER_BITS_PP (14),
        .DEBOUNCE_TIMER_VALUE_PP(DEB),
        .DEBOUNCE_TIMER_BITS_PP (7)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .left_button (left_button),
        .right_button(right_button),
        .x_increment (x_increment),
        .y_increment (y_increment),
        .data_ready  (data_ready),
        .read        (read),
        .error_no_ack(error_no_ack)
    );

    // Tracks data_ready pulses and the length of each host inhibit (both pins held low by the host).
    always @(negedge clk) begin
        if (data_ready === 1'b1) begin
            ready_cycles++;
            if (!ready_prev) ready_pulses++;
        end
        ready_prev = (data_ready === 1'b1);
        if (ps2_clk === 1'b0 && ps2_data === 1'b0 && !dev_data_low) begin
            low_run++;
        end else begin
            if (low_run > 4 * HALF) begin
                last_inhibit = low_run;
                inhibit_seen++;
            end
            low_run = 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic sendBit(input logic b);
        dev_data_low = ~b;
        repeat (10) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] value, input logic bad_parity);
        logic [10:0] frame;
        frame = {1'b1, (~^value) ^ bad_parity, value, 1'b0};
        for (int i = 0; i < 11; i++) sendBit(frame[i]);
        dev_data_low = 1'b0;
    endtask

    task automatic applyPacket(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        applyStimulus(b0, 1'b0);
        applyStimulus(b1, 1'b0);
        applyStimulus(b2, 1'b0);
        repeat (5) @(negedge clk);
    endtask

    task automatic applyPartial(input int nbits);
        for (int i = 0; i < nbits; i++) sendBit(i != 0);
        dev_data_low = 1'b0;
    endtask

    task automatic stall();
        repeat (WD + 500) @(negedge clk);
    endtask

    // Plays the device side of a host-to-device transfer: clocks in 10 bits, then the ACK slot.
    task automatic receiveHostCommand(input logic ack_low, output logic [9:0] rx_bits);
        int waited;
        waited = 0;
        rx_bits = '0;
        while (!(ps2_clk === 1'b1 && ps2_data === 1'b0 && !dev_clk_low) && waited < 4 * WD) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("tx_start_seen", 32'(waited < 4 * WD), 32'd1);
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clk);
            rx_bits[i] = ps2_data;
        end
        dev_data_low = ack_low;
        repeat (10) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic checkCommand(input string tag, input logic [9:0] rx_bits, input int seen_before);
        checkOutput({tag, "_cmd"}, 32'(rx_bits[7:0]), 32'h0F4);
        checkOutput({tag, "_parity_odd"}, 32'(^rx_bits[8:0]), 32'd1);
        checkOutput({tag, "_stop"}, 32'(rx_bits[9]), 32'd1);
        checkOutput({tag, "_inhibit_count"}, 32'(inhibit_seen - seen_before), 32'd1);
        checkOutput({tag, "_inhibit_len"}, 32'(last_inhibit), 32'(WD));
    endtask

    initial begin
        logic [9:0] bits;
        int pulses0;
        int cycles0;
        int seen0;

        reset = 1'b1;
        read  = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs",
                    {8'd0, left_button, right_button, data_ready, error_no_ack, x_increment, y_increment},
                    32'd0);
        checkOutput("reset_pins", {30'd0, ps2_clk, ps2_data}, 32'd3);

        $display("[TB] power-on handshake");
        applyStimulus(8'hAA, 1'b0);
        applyStimulus(8'h00, 1'b0);
        seen0 = inhibit_seen;
        receiveHostCommand(1'b1, bits);
        checkCommand("init", bits, seen0);
        checkOutput("init_no_error", 32'(error_no_ack), 32'd0);
        applyStimulus(8'hFA, 1'b0);

        $display("[TB] stream packets");
        pulses0 = ready_pulses; cycles0 = ready_cycles;
        applyPacket(8'h28, 8'h05, 8'hFF);
        checkOutput("p1_pulses", 32'(ready_pulses - pulses0), 32'd1);
        checkOutput("p1_width", 32'(ready_cycles - cycles0), 32'd1);
        checkOutput("p1_buttons", {30'd0, left_button, right_button}, 32'd0);
        checkOutput("p1_x", 32'(x_increment), 32'h005);
        checkOutput("p1_y", 32'(y_increment), 32'h1FF);

        pulses0 = ready_pulses;
        applyPacket(8'h19, 8'hF6, 8'h14);
        checkOutput("p2_pulses", 32'(ready_pulses - pulses0), 32'd1);
        checkOutput("p2_buttons", {30'd0, left_button, right_button}, 32'd2);
        checkOutput("p2_x", 32'(x_increment), 32'h1F6);
        checkOutput("p2_y", 32'(y_increment), 32'h014);

        $display("[TB] unread packets overwrite");
        read = 1'b0;
        pulses0 = ready_pulses;
        applyPacket(8'h0A, 8'h00, 8'h00);
        checkOutput("p3_ready_held", 32'(data_ready), 32'd1);
        checkOutput("p3_buttons", {30'd0, left_button, right_button}, 32'd1);
        checkOutput("p3_xy", {14'd0, x_increment, y_increment}, 32'd0);
        applyPacket(8'h28, 8'h7F, 8'h80);
        checkOutput("p4_ready_held", 32'(data_ready), 32'd1);
        checkOutput("p4_x", 32'(x_increment), 32'h07F);
        checkOutput("p4_y", 32'(y_increment), 32'h180);
        checkOutput("p34_pulses", 32'(ready_pulses - pulses0), 32'd1);
        read = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("read_clears", 32'(data_ready), 32'd0);

        $display("[TB] inter-byte timeout");
        pulses0 = ready_pulses;
        applyStimulus(8'h28, 1'b0);
        applyStimulus(8'h05, 1'b0);
        stall();
        applyPacket(8'h19, 8'hF6, 8'h14);
        checkOutput("to_pulses", 32'(ready_pulses - pulses0), 32'd1);
        checkOutput("to_x", 32'(x_increment), 32'h1F6);
        checkOutput("to_y", 32'(y_increment), 32'h014);

        $display("[TB] mid-frame timeout");
        pulses0 = ready_pulses;
        applyPartial(4);
        stall();
        applyPacket(8'h09, 8'h12, 8'h34);
        checkOutput("mf_pulses", 32'(ready_pulses - pulses0), 32'd1);
        checkOutput("mf_buttons", {30'd0, left_button, right_button}, 32'd2);
        checkOutput("mf_x", 32'(x_increment), 32'h012);
        checkOutput("mf_y", 32'(y_increment), 32'h034);

        $display("[TB] byte0 without bit3");
        pulses0 = ready_pulses;
        applyPacket(8'h00, 8'h05, 8'h07);
        checkOutput("sync_pulses", 32'(ready_pulses - pulses0), 32'd0);
        checkOutput("sync_x_hold", 32'(x_increment), 32'h012);
        checkOutput("sync_lb_hold", 32'(left_button), 32'd1);

        $display("[TB] bad parity on byte1");
        pulses0 = ready_pulses;
        applyStimulus(8'h28, 1'b0);
        applyStimulus(8'h05, 1'b1);
        applyStimulus(8'hFF, 1'b0);
        repeat (5) @(negedge clk);
`ifdef PS2_PARITY_CHECK_EN
        checkOutput("par_pulses", 32'(ready_pulses - pulses0), 32'd0);
        checkOutput("par_x", 32'(x_increment), 32'h012);
`else
        checkOutput("par_pulses", 32'(ready_pulses - pulses0), 32'd1);
        checkOutput("par_x", 32'(x_increment), 32'h005);
`endif
        stall();

        $display("[TB] reset mid-frame, then missing ACK");
        applyPartial(4);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst2_outputs",
                    {8'd0, left_button, right_button, data_ready, error_no_ack, x_increment, y_increment},
                    32'd0);
        applyStimulus(8'hAA, 1'b0);
        applyStimulus(8'h03, 1'b0);
        seen0 = inhibit_seen;
        receiveHostCommand(1'b0, bits);
        repeat (5) @(negedge clk);
        checkCommand("noack", bits, seen0);
        checkOutput("noack_error", 32'(error_no_ack), 32'd1);
        seen0 = inhibit_seen;
        receiveHostCommand(1'b1, bits);
        checkCommand("retry", bits, seen0);
        checkOutput("retry_error_sticky", 32'(error_no_ack), 32'd1);
        applyStimulus(8'hFA, 1'b0);
        pulses0 = ready_pulses;
        applyPacket(8'h2A, 8'hFF, 8'h01);
        checkOutput("p5_pulses", 32'(ready_pulses - pulses0), 32'd1);
        checkOutput("p5_buttons", {30'd0, left_button, right_button}, 32'd1);
        checkOutput("p5_x", 32'(x_increment), 32'h0FF);
        checkOutput("p5_y", 32'(y_increment), 32'h101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
